// File: rtl/alu_selftest_pkg.sv
// Shared definitions for the ALU self-test driver: FSM encodings, uio bit map,
// MISR defaults and the single-step MISR update used by both the MISR and the top.
package alu_selftest_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam int UIO_START = 4;
  localparam int UIO_BUSY  = 5;
  localparam int UIO_DONE  = 6;
  localparam int UIO_PASS  = 7;

  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;
  localparam logic [15:0] SIG_INIT_DEF  = 16'hFFFF;
  localparam logic [11:0] VEC_LAST      = 12'd4095;

  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [7:0]  din,
                                            input logic [15:0] poly);
    misr_step = {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ {8'h00, din};
  endfunction

endpackage

// File: rtl/alu_selftest_driver_misr16.sv
// 16-bit multiple-input signature register compressing one 8-bit ALU response per enable.
module misr16
  import alu_selftest_pkg::*;
#(
  parameter logic [15:0] POLY = MISR_POLY_DEF,
  parameter logic [15:0] INIT = SIG_INIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] sig
);

  // load wins over en so a restart never folds in a stale response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sig <= INIT;
    else if (load) sig <= seed;
    else if (en)   sig <= misr_step(sig, din, POLY);
  end

endmodule

// File: rtl/alu_selftest_driver.sv
// ALU self-test initiator: sweeps all {opcode, B, A} vectors, compresses the
// responses into a MISR signature and reports busy/done/pass on uio_out.
module alu_selftest_driver
  import alu_selftest_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] SIG_INIT      = SIG_INIT_DEF,
  parameter logic [15:0] MISR_POLY     = MISR_POLY_DEF,
  parameter logic [15:0] EXP_SIG       = 16'h0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [11:0] idx;
  logic [11:0] idx_inc;
  logic [3:0]  cnt;
  logic        sync1;
  logic        sync2;
  logic        prev;
  logic        start_rise;
  logic [7:0]  vec_out;
  logic [3:0]  op_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] sig;
  logic [15:0] sig_nxt;
  logic        unused_pins;

  assign unused_pins = ena ^ (^uio_in[7:5]) ^ (^uio_in[3:0]);
  assign start_rise  = sync2 & ~prev;
  assign idx_inc     = idx + 12'd1;
  // value the MISR takes on the final SAMPLE edge, needed to register pass and DONE outputs
  assign sig_nxt     = misr_step(sig, ui_in, MISR_POLY);

  misr16 #(
    .POLY (MISR_POLY),
    .INIT (SIG_INIT)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_rise),
    .seed  (SIG_INIT),
    .en    (state == ST_SAMPLE),
    .din   (ui_in),
    .sig   (sig)
  );

  // Synchronizer resets high so a start pin held across reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= uio_in[UIO_START];
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= 12'd0;
      cnt     <= 4'd0;
      vec_out <= 8'h00;
      op_out  <= 4'h0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else if (start_rise) begin
      state   <= ST_SETTLE;
      idx     <= 12'd0;
      cnt     <= 4'd0;
      vec_out <= 8'h00;
      op_out  <= 4'h0;
      busy    <= 1'b1;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cnt == CNT_LAST) state <= ST_SAMPLE;
          else                 cnt   <= cnt + 4'd1;
        end
        ST_SAMPLE: begin
          if (idx == VEC_LAST) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (sig_nxt == EXP_SIG);
            vec_out <= sig_nxt[7:0];
            op_out  <= sig_nxt[11:8];
          end else begin
            state   <= ST_SETTLE;
            idx     <= idx_inc;
            cnt     <= 4'd0;
            vec_out <= idx_inc[7:0];
            op_out  <= idx_inc[11:8];
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = vec_out;
  assign uio_out = {pass, done, busy, 1'b0, op_out};
  assign uio_oe  = 8'b1110_1111;

endmodule

// File: tb/tb_alu_selftest_driver.sv
// Directed bench for alu_selftest_driver with a behavioural 16-op ALU answering on ui_in.
module tb_alu_selftest_driver;

  function automatic logic [7:0] alu_resp(input logic [3:0] op, input logic [3:0] b,
                                          input logic [3:0] a, input int mode);
    logic [4:0] w;
    logic [7:0] p;
    logic       err;
    logic [3:0] r;
    w   = 5'd0;
    err = 1'b0;
    p   = {4'h0, a} * {4'h0, b};
    case (op)
      4'd0:  w = {1'b0, a} + {1'b0, b};
      4'd1:  w = {1'b0, a} - {1'b0, b};
      4'd2:  w = {1'b0, a & b};
      4'd3:  w = {1'b0, a | b};
      4'd4:  w = {1'b0, a ^ b};
      4'd5:  w = {1'b0, ~a};
      4'd6:  w = {a, 1'b0};
      4'd7:  w = {a[0], 1'b0, a[3:1]};
      4'd8:  w = {1'b0, a} + 5'd1;
      4'd9:  w = {1'b0, a} - 5'd1;
      4'd10: w = {|p[7:4], p[3:0]};
      4'd11: w = {1'b0, a[2:0], a[3]};
      4'd12: w = {1'b0, ~(a & b)};
      4'd13: w = {1'b0, ~(a | b)};
      4'd14: w = {1'b0, b};
      default: begin
        if (b == 4'd0) err = 1'b1;
        else           w = {1'b0, a / b};
      end
    endcase
    if (mode == 1 && op == 4'd3) w[0] = 1'b1;
    r = w[3:0];
    if (mode == 2) alu_resp = 8'h00;
    else           alu_resp = {(r == 4'd0), w[4], r[3], err, r};
  endfunction

  function automatic logic [15:0] golden_sig(input int mode);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int op = 0; op < 16; op++)
      for (int b = 0; b < 16; b++)
        for (int a = 0; a < 16; a++)
          s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
              ^ {8'h00, alu_resp(4'(op), 4'(b), 4'(a), mode)};
    golden_sig = s;
  endfunction

  localparam logic [15:0] GOLD = golden_sig(0);

  logic       clk;
  logic       rst_n;
  logic       start;
  int         mode;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  int         n_tests;
  int         n_fail;
  logic [15:0] gz;
  logic [15:0] gf;

  alu_selftest_driver #(
    .SETTLE_CYCLES (2),
    .SIG_INIT      (16'hFFFF),
    .MISR_POLY     (16'h1021),
    .EXP_SIG       (GOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  ({3'b000, start, 4'b0000}),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb ui_in = alu_resp(uio_out[3:0], uo_out[7:4], uo_out[3:0], mode);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Fresh rising edge on the start pin; returns #1 after the edge that acts on it.
  task automatic start_run(input string tag);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_busy"}, uio_out[5], 1'b1);
    chk({tag, "_done_clr"}, uio_out[6], 1'b0);
    chk({tag, "_uo0"}, uo_out, 8'h00);
    chk({tag, "_op0"}, uio_out[3:0], 4'h0);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (uio_out[6] !== 1'b1 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, uio_out[6], 1'b1);
    chk({tag, "_busy_off"}, uio_out[5], 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    mode    = 2;
    gz      = golden_sig(2);
    gf      = golden_sig(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hEF);
    chk("rst_busy", uio_out[5], 1'b0);
    chk("rst_done", uio_out[6], 1'b0);
    chk("rst_pass", uio_out[7], 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // ui_in tied to zero: exact start latency and run length
    repeat (3) @(posedge clk);
    @(negedge clk) start = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("z_busy_early", uio_out[5], 1'b0);
    @(posedge clk);
    #1;
    chk("z_busy", uio_out[5], 1'b1);
    chk("z_uo0", uo_out, 8'h00);
    chk("z_op0", uio_out[3:0], 4'h0);
    repeat (3) @(posedge clk);
    #1 chk("z_uo1", uo_out, 8'h01);
    repeat (12284) @(posedge clk);
    #1 chk("z_done_early", uio_out[6], 1'b0);
    @(posedge clk);
    #1;
    chk("z_done", uio_out[6], 1'b1);
    chk("z_sig_lo", uo_out, gz[7:0]);
    chk("z_sig_hi", uio_out[3:0], gz[11:8]);
    chk("z_pass", uio_out[7], (gz == GOLD));
    @(posedge clk);
    #1 chk("z_hold", uio_out[6], 1'b1);

    // healthy ALU
    mode = 0;
    start_run("g");
    wait_done("g", 12400);
    chk("g_pass", uio_out[7], 1'b1);
    chk("g_sig_lo", uo_out, GOLD[7:0]);
    chk("g_sig_hi", uio_out[3:0], GOLD[11:8]);

    // Result[0] stuck at 1 for opcode 3 only
    mode = 1;
    start_run("f");
    wait_done("f", 12400);
    chk("f_pass", uio_out[7], (gf == GOLD));
    chk("f_sig_lo", uo_out, gf[7:0]);
    chk("f_sig_hi", uio_out[3:0], gf[11:8]);

    // restart at vector 1000
    mode = 0;
    start_run("r1");
    begin
      int n;
      n = 0;
      while (!(uo_out == 8'hE8 && uio_out[3:0] == 4'h3) && n < 4000) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("r_vec1000", {uio_out[3:0], uo_out}, 12'h3E8);
    end
    start_run("r2");
    wait_done("r2", 12400);
    chk("r_pass", uio_out[7], 1'b1);
    chk("r_sig_lo", uo_out, GOLD[7:0]);
    chk("r_sig_hi", uio_out[3:0], GOLD[11:8]);

    // asynchronous reset mid-SETTLE with start held high
    start_run("a");
    repeat (19) @(posedge clk);
    #1 chk("a_pre_uo", uo_out, 8'h06);
    #1 rst_n = 1'b0;
    #1;
    chk("a_rst_uo", uo_out, 8'h00);
    chk("a_rst_uio", uio_out, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("a_held_busy", uio_out[5], 1'b0);
    chk("a_held_uio", uio_out, 8'h00);
    start_run("a2");
    wait_done("a2", 12400);
    chk("a2_pass", uio_out[7], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
